// File: rtl/pa_wb_pkg.sv
// Shared types and default widths for the M4 write-back arbiter.
// Optional bypass path is enabled by defining MUL_WB_BYPASS_EN.
package pa_wb_pkg;

    localparam int WORD_SIZE_D       = 32;
    localparam int INSTR_TYPE_SZ_D   = 3;
    localparam int ROB_ENTRY_WIDTH_D = 3;
    localparam int FIFO_DEPTH_D      = 8;
    localparam int M_PIPE_LAT_D      = 4;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_M   = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [INSTR_TYPE_SZ_D-1:0]   instruction_type;
        logic [WORD_SIZE_D-1:0]       pc;
        logic [WORD_SIZE_D-1:0]       result;
        logic [ROB_ENTRY_WIDTH_D-1:0] rob_id;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries; pop and push together is
// legal at any occupancy, and the popped entry is always the old head.
module wb_fifo
    import pa_wb_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH_D,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  wb_entry_t     din,
    output wb_entry_t     head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    wb_entry_t      mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mul_wb_arbiter.sv
// Owns the single ROB write port: ALU first, then buffered M results.
// Define MUL_WB_BYPASS_EN to let a lone M result skip the FIFO.
module mul_wb_arbiter
    import pa_wb_pkg::*;
#(
    parameter  int WORD_SIZE       = WORD_SIZE_D,
    parameter  int INSTR_TYPE_SZ   = INSTR_TYPE_SZ_D,
    parameter  int ROB_ENTRY_WIDTH = ROB_ENTRY_WIDTH_D,
    parameter  int FIFO_DEPTH      = FIFO_DEPTH_D,
    parameter  int M_PIPE_LAT      = M_PIPE_LAT_D,
    localparam int CW              = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       m_valid,
    input  logic [INSTR_TYPE_SZ-1:0]   m_instruction_type,
    input  logic [WORD_SIZE-1:0]       m_pc,
    input  logic [WORD_SIZE-1:0]       m_result,
    input  logic [ROB_ENTRY_WIDTH-1:0] m_rob_id,
    input  logic                       alu_valid,
    input  logic [INSTR_TYPE_SZ-1:0]   alu_instruction_type,
    input  logic [WORD_SIZE-1:0]       alu_pc,
    input  logic [WORD_SIZE-1:0]       alu_result,
    input  logic [ROB_ENTRY_WIDTH-1:0] alu_rob_id,
    output logic                       rob_wr_en,
    output logic                       rob_wr_src,
    output logic [INSTR_TYPE_SZ-1:0]   rob_wr_instruction_type,
    output logic [WORD_SIZE-1:0]       rob_wr_pc,
    output logic [WORD_SIZE-1:0]       rob_wr_result,
    output logic [ROB_ENTRY_WIDTH-1:0] rob_wr_id,
    output logic                       m_stall,
    output logic [CW-1:0]              fifo_count,
    output logic                       overflow
);

    localparam int STALL_TH = FIFO_DEPTH - M_PIPE_LAT;

    wb_entry_t m_entry;
    wb_entry_t alu_entry;
    wb_entry_t head;
    wb_entry_t sel_entry;
    wb_src_e   sel_src;
    logic      sel_en;
    logic      push;
    logic      pop;
    logic      bypass;
    logic      drop;
    logic      full;
    logic      empty;
    logic [CW-1:0] next_count;

    assign m_entry = '{
        instruction_type: m_instruction_type,
        pc:               m_pc,
        result:           m_result,
        rob_id:           m_rob_id
    };

    assign alu_entry = '{
        instruction_type: alu_instruction_type,
        pc:               alu_pc,
        result:           alu_result,
        rob_id:           alu_rob_id
    };

    always_comb begin
        pop    = !alu_valid && !empty;
`ifdef MUL_WB_BYPASS_EN
        bypass = !alu_valid && empty && m_valid;
`else
        bypass = 1'b0;
`endif
        push   = m_valid && !bypass;
        drop   = push && full && !pop;
        next_count = fifo_count
                   + CW'(push && !drop)
                   - CW'(pop);
    end

    always_comb begin
        sel_en    = 1'b0;
        sel_src   = WB_SRC_ALU;
        sel_entry = alu_entry;
        unique case (1'b1)
            alu_valid: begin
                sel_en = 1'b1;
            end
            pop: begin
                sel_en    = 1'b1;
                sel_src   = WB_SRC_M;
                sel_entry = head;
            end
            bypass: begin
                sel_en    = 1'b1;
                sel_src   = WB_SRC_M;
                sel_entry = m_entry;
            end
            default: begin
                sel_en = 1'b0;
            end
        endcase
    end

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (m_entry),
        .head    (head),
        .count   (fifo_count),
        .full    (full),
        .empty   (empty)
    );

    // Data registers only load on a write so idle cycles hold the last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rob_wr_en               <= 1'b0;
            rob_wr_src              <= 1'b0;
            rob_wr_instruction_type <= '0;
            rob_wr_pc               <= '0;
            rob_wr_result           <= '0;
            rob_wr_id               <= '0;
            m_stall                 <= 1'b0;
            overflow                <= 1'b0;
        end else begin
            rob_wr_en <= sel_en;
            if (sel_en) begin
                rob_wr_src              <= sel_src;
                rob_wr_instruction_type <= sel_entry.instruction_type;
                rob_wr_pc               <= sel_entry.pc;
                rob_wr_result           <= sel_entry.result;
                rob_wr_id               <= sel_entry.rob_id;
            end
            m_stall  <= (next_count >= CW'(STALL_TH));
            overflow <= overflow | drop;
        end
    end

endmodule

// File: tb/tb_mul_wb_arbiter.sv
// Directed bench for mul_wb_arbiter with a queue-based reference model.
// Honours MUL_WB_BYPASS_EN for the expected M-result latency.
module tb_mul_wb_arbiter;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m_valid;
    logic [2:0]  m_instruction_type;
    logic [31:0] m_pc;
    logic [31:0] m_result;
    logic [2:0]  m_rob_id;
    logic        alu_valid;
    logic [2:0]  alu_instruction_type;
    logic [31:0] alu_pc;
    logic [31:0] alu_result;
    logic [2:0]  alu_rob_id;
    logic        rob_wr_en;
    logic        rob_wr_src;
    logic [2:0]  rob_wr_instruction_type;
    logic [31:0] rob_wr_pc;
    logic [31:0] rob_wr_result;
    logic [2:0]  rob_wr_id;
    logic        m_stall;
    logic [3:0]  fifo_count;
    logic        overflow;

    mul_wb_arbiter dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .m_valid                 (m_valid),
        .m_instruction_type      (m_instruction_type),
        .m_pc                    (m_pc),
        .m_result                (m_result),
        .m_rob_id                (m_rob_id),
        .alu_valid               (alu_valid),
        .alu_instruction_type    (alu_instruction_type),
        .alu_pc                  (alu_pc),
        .alu_result              (alu_result),
        .alu_rob_id              (alu_rob_id),
        .rob_wr_en               (rob_wr_en),
        .rob_wr_src              (rob_wr_src),
        .rob_wr_instruction_type (rob_wr_instruction_type),
        .rob_wr_pc               (rob_wr_pc),
        .rob_wr_result           (rob_wr_result),
        .rob_wr_id               (rob_wr_id),
        .m_stall                 (m_stall),
        .fifo_count              (fifo_count),
        .overflow                (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  t;
        logic [31:0] pc;
        logic [31:0] res;
        logic [2:0]  id;
    } ent_t;

    ent_t q[$];
    ent_t exp_e;
    logic exp_en;
    logic exp_src;
    logic exp_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t",
                      name, act, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        exp_e   = '{3'd0, 32'd0, 32'd0, 3'd0};
        exp_en  = 1'b0;
        exp_src = 1'b0;
        exp_ovf = 1'b0;
    endtask

    // Reference: one write per cycle, ALU first, M results in arrival order.
    task automatic model_step();
        ent_t me;
        ent_t ae;
        me = '{m_instruction_type, m_pc, m_result, m_rob_id};
        ae = '{alu_instruction_type, alu_pc, alu_result, alu_rob_id};
        if (alu_valid) begin
            exp_en = 1'b1; exp_src = 1'b0; exp_e = ae;
            if (m_valid) begin
                if (q.size() == DEPTH) exp_ovf = 1'b1;
                else q.push_back(me);
            end
        end else if (q.size() > 0) begin
            exp_en = 1'b1; exp_src = 1'b1; exp_e = q.pop_front();
            if (m_valid) q.push_back(me);
        end else if (m_valid) begin
`ifdef MUL_WB_BYPASS_EN
            exp_en = 1'b1; exp_src = 1'b1; exp_e = me;
`else
            exp_en = 1'b0;
            q.push_back(me);
`endif
        end else begin
            exp_en = 1'b0;
        end
    endtask

    task automatic compare_all();
        chk("wr_en", rob_wr_en, exp_en);
        chk("wr_src", rob_wr_src, exp_src);
        chk("wr_type", rob_wr_instruction_type, exp_e.t);
        chk("wr_pc", rob_wr_pc, exp_e.pc);
        chk("wr_result", rob_wr_result, exp_e.res);
        chk("wr_id", rob_wr_id, exp_e.id);
        chk("fifo_count", fifo_count, q.size());
        chk("m_stall", m_stall, q.size() >= 4);
        chk("overflow", overflow, exp_ovf);
    endtask

    task automatic tick();
        if (reset_n) model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_m(input logic v, input logic [2:0] id,
                         input logic [31:0] res);
        m_valid            = v;
        m_rob_id           = id;
        m_result           = res;
        m_pc               = 32'h8000_0000 | (res << 2);
        m_instruction_type = id ^ 3'd5;
    endtask

    task automatic set_a(input logic v, input logic [2:0] id,
                         input logic [31:0] res);
        alu_valid            = v;
        alu_rob_id           = id;
        alu_result           = res;
        alu_pc               = 32'h4000_0000 + (res << 2);
        alu_instruction_type = id ^ 3'd2;
    endtask

    initial begin
        reset_n = 1'b0;
        set_m(1'b0, 3'd0, 32'd0);
        set_a(1'b0, 3'd0, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("reset_count", fifo_count, 0);
        reset_n = 1'b1;

        // Lone M result
        set_m(1'b1, 3'd5, 32'hDEAD_BEEF);
        tick();
        set_m(1'b0, 3'd0, 32'd0);
`ifndef MUL_WB_BYPASS_EN
        chk("lone_m_early", rob_wr_en, 0);
        tick();
`endif
        chk("lone_m_en", rob_wr_en, 1);
        chk("lone_m_src", rob_wr_src, 1);
        chk("lone_m_id", rob_wr_id, 5);
        chk("lone_m_res", rob_wr_result, 32'hDEAD_BEEF);
        tick();
        chk("lone_m_hold", rob_wr_result, 32'hDEAD_BEEF);

        // Contention: ALU busy with M arriving each cycle
        for (int i = 1; i <= 5; i++) begin
            set_a(1'b1, 3'(i + 2), 32'h100 + i);
            set_m(1'b1, 3'(i), 32'h200 + i);
            tick();
            chk("cont_alu_src", rob_wr_src, 0);
        end
        set_a(1'b0, 3'd0, 32'd0);
        set_m(1'b0, 3'd0, 32'd0);
        chk("cont_count", fifo_count, 5);
        chk("cont_stall", m_stall, 1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("drain_id", rob_wr_id, i);
            chk("drain_res", rob_wr_result, 32'h200 + i);
        end
        chk("drain_stall", m_stall, 0);
        tick();
        chk("drain_idle", rob_wr_en, 0);

        // Wrap-around: 20 M results with interleaved ALU bursts
        begin
            int sent;
            sent = 0;
            for (int i = 0; i < 40; i++) begin
                set_a((i % 4 == 1) || (i % 4 == 2), 3'(i), 32'h3000 + i);
                if (i % 2 == 0 && sent < 20) begin
                    set_m(1'b1, 3'(sent), 32'h5000 + sent);
                    sent++;
                end else begin
                    set_m(1'b0, 3'd0, 32'd0);
                end
                tick();
            end
        end
        set_a(1'b0, 3'd0, 32'd0);
        set_m(1'b0, 3'd0, 32'd0);
        repeat (10) tick();
        chk("wrap_empty", fifo_count, 0);

        // Fill to full with the ALU busy, then pop and push together
        for (int k = 1; k <= 8; k++) begin
            set_a(1'b1, 3'd7, 32'h700 + k);
            set_m(1'b1, 3'(k), 32'h1000 + k);
            tick();
        end
        chk("full_count", fifo_count, 8);
        chk("full_stall", m_stall, 1);
        set_a(1'b0, 3'd0, 32'd0);
        set_m(1'b1, 3'd1, 32'h1009);
        tick();
        chk("poppush_count", fifo_count, 8);
        chk("poppush_ovf", overflow, 0);
        chk("poppush_head", rob_wr_result, 32'h1001);

        // Overflow: full, ALU busy, another M arrives
        set_a(1'b1, 3'd6, 32'h777);
        set_m(1'b1, 3'd2, 32'h2000);
        tick();
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", fifo_count, 8);
        set_a(1'b0, 3'd0, 32'd0);
        set_m(1'b0, 3'd0, 32'd0);
        for (int k = 2; k <= 9; k++) begin
            tick();
            chk("ovf_drain", rob_wr_result, 32'h1000 + k);
        end
        tick();
        chk("ovf_idle", rob_wr_en, 0);
        chk("ovf_sticky", overflow, 1);

        // Reset mid-stream with 3 entries buffered
        for (int k = 0; k < 3; k++) begin
            set_a(1'b1, 3'd4, 32'h900 + k);
            set_m(1'b1, 3'(k), 32'hA00 + k);
            tick();
        end
        chk("pre_rst_count", fifo_count, 3);
        set_a(1'b0, 3'd0, 32'd0);
        set_m(1'b0, 3'd0, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_en", rob_wr_en, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_stall", m_stall, 0);
        tick();
        reset_n = 1'b1;
        set_m(1'b1, 3'd6, 32'hCAFE);
        tick();
        set_m(1'b0, 3'd0, 32'd0);
`ifndef MUL_WB_BYPASS_EN
        tick();
`endif
        chk("post_rst_en", rob_wr_en, 1);
        chk("post_rst_src", rob_wr_src, 1);
        chk("post_rst_id", rob_wr_id, 6);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
